// File: rtl/bp_cce_inst_fetch.sv
// CCE microcode fetch: owns the instruction RAM and PC, sequences boot-time
// load/readback over the config bus, then streams one instruction per cycle.
module bp_cce_inst_fetch #(
  parameter int num_cce_instr_ram_els_p = 256,
  parameter int cce_instr_width_p       = 48,
  parameter bit check_cfg_p             = 1'b1,
  localparam int pc_width_lp            = $clog2(num_cce_instr_ram_els_p)
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         ucode_mode_i,
  input  logic                         cfg_w_v_i,
  input  logic                         cfg_r_v_i,
  input  logic [pc_width_lp-1:0]       cfg_addr_i,
  input  logic [cce_instr_width_p-1:0] cfg_data_i,
  output logic                         cfg_ready_o,
  output logic [cce_instr_width_p-1:0] cfg_data_o,
  output logic                         cfg_data_v_o,
  input  logic                         stall_i,
  input  logic                         branch_v_i,
  input  logic [pc_width_lp-1:0]       branch_target_i,
  output logic [cce_instr_width_p-1:0] inst_o,
  output logic                         inst_v_o,
  output logic [pc_width_lp-1:0]       pc_o
);

  typedef enum logic [1:0] {e_reset, e_boot, e_run} state_e;

  state_e                         state_q, state_d;
  logic [pc_width_lp-1:0]         pc_q, pc_d;
  logic                           cfg_data_v_q, cfg_data_v_d;
  logic [cce_instr_width_p-1:0]   cfg_hold_q, cfg_hold_d;

  logic [pc_width_lp-1:0]         ram_addr;
  logic                           ram_we, ram_re;
  logic [cce_instr_width_p-1:0]   ram_q;
  logic [cce_instr_width_p-1:0]   mem [num_cce_instr_ram_els_p];

  logic cfg_req;
  assign cfg_req = cfg_w_v_i | cfg_r_v_i;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ram_addr     = pc_q;
    ram_we       = 1'b0;
    ram_re       = 1'b0;
    cfg_data_v_d = 1'b0;
    // Readback data only lives on the RAM output for one cycle; latch it so
    // cfg_data_o survives later fetches.
    cfg_hold_d   = cfg_data_v_q ? ram_q : cfg_hold_q;
    case (state_q)
      e_reset: state_d = e_boot;
      e_boot: begin
        ram_addr     = cfg_addr_i;
        ram_we       = cfg_w_v_i;
        ram_re       = cfg_r_v_i & ~cfg_w_v_i;
        cfg_data_v_d = cfg_r_v_i & ~cfg_w_v_i;
        if (ucode_mode_i && !cfg_req) begin
          ram_addr = '0;
          ram_re   = 1'b1;
          pc_d     = '0;
          state_d  = e_run;
        end
      end
      e_run: begin
        if (stall_i)         ram_addr = pc_q;
        else if (branch_v_i) ram_addr = branch_target_i;
        else                 ram_addr = pc_q + pc_width_lp'(1);
        ram_re = 1'b1;
        pc_d   = ram_addr;
        if (!ucode_mode_i && !stall_i) state_d = e_boot;
      end
      default: state_d = e_reset;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= e_reset;
      pc_q         <= '0;
      cfg_data_v_q <= 1'b0;
      cfg_hold_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      cfg_data_v_q <= cfg_data_v_d;
      cfg_hold_q   <= cfg_hold_d;
    end
  end

  // Single-port RAM, contents and read register are never reset.
  always_ff @(posedge clk_i) begin
    if (ram_we)      mem[ram_addr] <= cfg_data_i;
    else if (ram_re) ram_q         <= mem[ram_addr];
  end

  assign inst_o       = ram_q;
  assign inst_v_o     = (state_q == e_run);
  assign pc_o         = pc_q;
  assign cfg_ready_o  = (state_q == e_boot);
  assign cfg_data_v_o = cfg_data_v_q;
  assign cfg_data_o   = cfg_data_v_q ? ram_q : cfg_hold_q;

  a_no_cfg_rw_collide: assert property (@(posedge clk_i) disable iff (reset_i || !check_cfg_p)
    !(state_q == e_boot && cfg_w_v_i && cfg_r_v_i));

endmodule
